alu_pipeline: RTL and testbench

ALU_PIPELINE -- requirements
Module: alu_pipeline

---
 rtl/cpu_pkg.sv | 18 +
 rtl/reg_file.sv | 74 +++++++
 rtl/alu_pipeline.sv | 199 +++++++++++++++++++
 tb/tb_alu_pipeline.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared opcode encodings and default datapath geometry for the ALU pipeline.
package cpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int NREG_DEF   = 32;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SLT = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_MUL = 3'b111
  } op_e;

endpackage

// File: rtl/reg_file.sv
// NREG x DATA_W register file: one write port, three asynchronous read ports
// (rs, rt, dbg) that see a same-edge write. Register 0 always reads zero.
module reg_file
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG   = NREG_DEF,
  localparam int REG_AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NSLOT = 2 ** REG_AW;

  logic [DATA_W-1:0] mem_r [NSLOT];
  logic              in_range_s;
  logic              wr_s;

  // Slots past NREG exist only to keep indexing in range; they are never written.
  generate
    if (NREG < NSLOT) begin : g_partial
      assign in_range_s = (32'(waddr) < 32'(NREG));
    end else begin : g_full
      assign in_range_s = 1'b1;
    end
  endgenerate

  assign wr_s = we && (waddr != '0) && in_range_s;

  function automatic logic [DATA_W-1:0] rd_port(
    input logic [REG_AW-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              wr,
    input logic [REG_AW-1:0] wa,
    input logic [DATA_W-1:0] wd
  );
    if (addr == '0) begin
      return '0;
    end else if (wr && (addr == wa)) begin
      return wd;
    end else begin
      return stored;
    end
  endfunction

  // Storage array with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NSLOT; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_s) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read ports with write-through bypass.
  always_comb begin
    rs_data  = rd_port(rs_addr, mem_r[rs_addr], wr_s, waddr, wdata);
    rt_data  = rd_port(rt_addr, mem_r[rt_addr], wr_s, waddr, wdata);
    dbg_data = rd_port(dbg_addr, mem_r[dbg_addr], wr_s, waddr, wdata);
  end

endmodule

// File: rtl/alu_pipeline.sv
// Three-stage ALU pipeline DX -> XM -> MW. Hazards are resolved by forwarding
// (FWD_EN=1) or a DX interlock (FWD_EN=0); MUL occupies DX for MUL_LAT cycles.
module alu_pipeline
  import cpu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NREG    = NREG_DEF,
  parameter int FWD_EN  = 1,
  parameter int MUL_LAT = 4,
  localparam int REG_AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [15:0]       in_imm,
  input  logic              in_use_imm,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(MUL_LAT);
  localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);

  logic              dx_valid_r;
  op_e               dx_op_r;
  logic [REG_AW-1:0] dx_rd_r;
  logic [REG_AW-1:0] dx_rs_r;
  logic [REG_AW-1:0] dx_rt_r;
  logic [DATA_W-1:0] dx_imm_r;
  logic              dx_use_imm_r;
  logic [CNT_W-1:0]  mul_cnt_r;

  logic              xm_valid_r;
  logic [REG_AW-1:0] xm_rd_r;
  logic [DATA_W-1:0] xm_data_r;

  logic [DATA_W-1:0] rs_rf_s;
  logic [DATA_W-1:0] rt_rf_s;
  logic [DATA_W-1:0] op_a_s;
  logic [DATA_W-1:0] rt_val_s;
  logic [DATA_W-1:0] op_b_s;
  logic [DATA_W-1:0] alu_res_s;
  logic              hazard_s;
  logic              mul_busy_s;
  logic              dx_advance_s;
  logic              accept_s;

  // Register 0 never matches, so it is never forwarded nor interlocked on.
  function automatic logic src_hit(
    input logic [REG_AW-1:0] src,
    input logic              v,
    input logic [REG_AW-1:0] rd
  );
    return v && (rd == src) && (src != '0);
  endfunction

  function automatic logic [DATA_W-1:0] alu(
    input op_e               op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic lt;
    lt = ($signed(a) < $signed(b));
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_SLT:  return {{(DATA_W-1){1'b0}}, lt};
      OP_SLL:  return a << b[SH_W-1:0];
      OP_SRL:  return a >> b[SH_W-1:0];
      OP_MUL:  return a * b;
      default: return '0;
    endcase
  endfunction

  reg_file #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_reg_file (
    .clk      (clk),
    .rst      (rst),
    .we       (wb_valid),
    .waddr    (wb_rd),
    .wdata    (wb_data),
    .rs_addr  (dx_rs_r),
    .rt_addr  (dx_rt_r),
    .dbg_addr (dbg_addr),
    .rs_data  (rs_rf_s),
    .rt_data  (rt_rf_s),
    .dbg_data (dbg_data)
  );

  // Operand selection: XM beats MW beats the register file.
  always_comb begin
    op_a_s   = rs_rf_s;
    rt_val_s = rt_rf_s;
    if (FWD_EN != 0) begin
      if (src_hit(dx_rs_r, xm_valid_r, xm_rd_r)) begin
        op_a_s = xm_data_r;
      end else if (src_hit(dx_rs_r, wb_valid, wb_rd)) begin
        op_a_s = wb_data;
      end else begin
        op_a_s = rs_rf_s;
      end
      if (src_hit(dx_rt_r, xm_valid_r, xm_rd_r)) begin
        rt_val_s = xm_data_r;
      end else if (src_hit(dx_rt_r, wb_valid, wb_rd)) begin
        rt_val_s = wb_data;
      end else begin
        rt_val_s = rt_rf_s;
      end
    end else begin
      op_a_s   = rs_rf_s;
      rt_val_s = rt_rf_s;
    end
    op_b_s    = dx_use_imm_r ? dx_imm_r : rt_val_s;
    alu_res_s = alu(dx_op_r, op_a_s, op_b_s);
  end

  // DX stall decision; rt is not a source when the immediate replaces it.
  always_comb begin
    hazard_s = 1'b0;
    if ((FWD_EN == 0) && dx_valid_r) begin
      hazard_s = src_hit(dx_rs_r, xm_valid_r, xm_rd_r) ||
                 src_hit(dx_rs_r, wb_valid, wb_rd) ||
                 (!dx_use_imm_r && (src_hit(dx_rt_r, xm_valid_r, xm_rd_r) ||
                                    src_hit(dx_rt_r, wb_valid, wb_rd)));
    end else begin
      hazard_s = 1'b0;
    end
    mul_busy_s   = dx_valid_r && (dx_op_r == OP_MUL) && (mul_cnt_r != '0);
    dx_advance_s = dx_valid_r && !mul_busy_s && !hazard_s;
  end

  assign in_ready = !dx_valid_r || dx_advance_s;
  assign accept_s = in_valid && in_ready;

  // DX stage: load on handshake, otherwise drain on advance and count MUL down.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dx_valid_r   <= 1'b0;
      dx_op_r      <= OP_ADD;
      dx_rd_r      <= '0;
      dx_rs_r      <= '0;
      dx_rt_r      <= '0;
      dx_imm_r     <= '0;
      dx_use_imm_r <= 1'b0;
      mul_cnt_r    <= '0;
    end else if (accept_s) begin
      dx_valid_r   <= 1'b1;
      dx_op_r      <= op_e'(in_op);
      dx_rd_r      <= in_rd;
      dx_rs_r      <= in_rs;
      dx_rt_r      <= in_rt;
      dx_imm_r     <= DATA_W'($signed(in_imm));
      dx_use_imm_r <= in_use_imm;
      mul_cnt_r    <= (op_e'(in_op) == OP_MUL) ? MUL_CNT_INIT : '0;
    end else begin
      if (dx_advance_s) begin
        dx_valid_r <= 1'b0;
      end
      if (mul_busy_s) begin
        mul_cnt_r <= mul_cnt_r - CNT_W'(1);
      end
    end
  end

  // XM and MW never stall; a DX stall shows up as an XM bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xm_valid_r <= 1'b0;
      xm_rd_r    <= '0;
      xm_data_r  <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
    end else begin
      xm_valid_r <= dx_advance_s;
      if (dx_advance_s) begin
        xm_rd_r   <= dx_rd_r;
        xm_data_r <= alu_res_s;
      end
      wb_valid <= xm_valid_r;
      wb_rd    <= xm_valid_r ? xm_rd_r : '0;
      wb_data  <= xm_valid_r ? xm_data_r : '0;
    end
  end

endmodule

// File: tb/tb_alu_pipeline.sv
// Directed scoreboard bench: unit 0 runs with forwarding, unit 1 with the interlock.
module tb_alu_pipeline;
  import cpu_pkg::*;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid_a   [2];
  logic          in_ready_a   [2];
  logic [2:0]    in_op_a      [2];
  logic [AW-1:0] in_rd_a      [2];
  logic [AW-1:0] in_rs_a      [2];
  logic [AW-1:0] in_rt_a      [2];
  logic [15:0]   in_imm_a     [2];
  logic          in_use_imm_a [2];
  logic          wb_valid_a   [2];
  logic [AW-1:0] wb_rd_a      [2];
  logic [DW-1:0] wb_data_a    [2];
  logic [AW-1:0] dbg_addr_a   [2];
  logic [DW-1:0] dbg_data_a   [2];

  alu_pipeline #(.DATA_W(DW), .NREG(NR), .FWD_EN(1), .MUL_LAT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
    .in_op(in_op_a[0]), .in_rd(in_rd_a[0]), .in_rs(in_rs_a[0]), .in_rt(in_rt_a[0]),
    .in_imm(in_imm_a[0]), .in_use_imm(in_use_imm_a[0]), .wb_valid(wb_valid_a[0]),
    .wb_rd(wb_rd_a[0]), .wb_data(wb_data_a[0]), .dbg_addr(dbg_addr_a[0]),
    .dbg_data(dbg_data_a[0])
  );

  alu_pipeline #(.DATA_W(DW), .NREG(NR), .FWD_EN(0), .MUL_LAT(4)) dut_il (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
    .in_op(in_op_a[1]), .in_rd(in_rd_a[1]), .in_rs(in_rs_a[1]), .in_rt(in_rt_a[1]),
    .in_imm(in_imm_a[1]), .in_use_imm(in_use_imm_a[1]), .wb_valid(wb_valid_a[1]),
    .wb_rd(wb_rd_a[1]), .wb_data(wb_data_a[1]), .dbg_addr(dbg_addr_a[1]),
    .dbg_data(dbg_data_a[1])
  );

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sb_size(input int u);
    return (u == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t sb_pop(input int u);
    if (u == 0) return q0.pop_front();
    else return q1.pop_front();
  endfunction

  // Monitor: every writeback must match the oldest expectation, including its cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    for (int u = 0; u < 2; u++) begin
      if (wb_valid_a[u] === 1'b1) begin
        if (sb_size(u) == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL u%0d_unexpected_wb: got rd=%0d data=0x%0h, want no writeback",
                   u, wb_rd_a[u], wb_data_a[u]);
        end else begin
          e = sb_pop(u);
          chk($sformatf("u%0d_wb_rd", u), 64'(wb_rd_a[u]), 64'(e.rd));
          chk($sformatf("u%0d_wb_data_rd%0d", u, e.rd), 64'(wb_data_a[u]), 64'(e.data));
          chk($sformatf("u%0d_wb_cycle_rd%0d", u, e.rd), 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  // Offer one instruction from a negedge; stalls are in_ready-low cycles seen first.
  task automatic issue(input int u, input op_e op, input int rd, input int rs, input int rt,
                       input logic [15:0] imm, input logic use_imm, input logic [DW-1:0] exp_data,
                       input int lat, input int exp_stall);
    int   st;
    int   c0;
    bit   acc;
    exp_t e;
    in_op_a[u]      = op;
    in_rd_a[u]      = AW'(rd);
    in_rs_a[u]      = AW'(rs);
    in_rt_a[u]      = AW'(rt);
    in_imm_a[u]     = imm;
    in_use_imm_a[u] = use_imm;
    in_valid_a[u]   = 1'b1;
    st  = 0;
    acc = 1'b0;
    c0  = 0;
    while (!acc && st < 40) begin
      c0  = cyc;
      acc = in_ready_a[u];
      @(posedge clk);
      if (!acc) begin
        st++;
        @(negedge clk);
      end
    end
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL u%0d_accept_rd%0d: got no handshake in %0d cycles, want acceptance", u, rd, st);
    end else begin
      e.rd   = AW'(rd);
      e.data = exp_data;
      e.cyc  = c0 + 1 + lat;
      if (u == 0) q0.push_back(e);
      else q1.push_back(e);
      chk($sformatf("u%0d_stall_before_rd%0d", u, rd), 64'(st), 64'(exp_stall));
    end
    @(negedge clk);
    in_valid_a[u] = 1'b0;
    in_op_a[u]    = 3'b111;
    in_rd_a[u]    = AW'(31);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic dbg(input int u, input int a, input logic [DW-1:0] exp);
    dbg_addr_a[u] = AW'(a);
    #1;
    chk($sformatf("u%0d_dbg_r%0d", u, a), 64'(dbg_data_a[u]), 64'(exp));
  endtask

  task automatic chk_idle_outputs(input string tag);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("%s_u%0d_wb_valid", tag, u), 64'(wb_valid_a[u]), 64'(0));
      chk($sformatf("%s_u%0d_wb_rd", tag, u), 64'(wb_rd_a[u]), 64'(0));
      chk($sformatf("%s_u%0d_wb_data", tag, u), 64'(wb_data_a[u]), 64'(0));
      chk($sformatf("%s_u%0d_in_ready", tag, u), 64'(in_ready_a[u]), 64'(1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 time units, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      in_valid_a[u] = 1'b0; in_op_a[u] = 3'b000; in_rd_a[u] = '0; in_rs_a[u] = '0;
      in_rt_a[u] = '0; in_imm_a[u] = '0; in_use_imm_a[u] = 1'b0; dbg_addr_a[u] = '0;
    end
    rst = 1'b1;
    #1 rst = 1'b0;
    idle(3);
    chk_idle_outputs("in_reset");
    rst = 1'b1;
    idle(1);
    chk_idle_outputs("after_release");

    // Forwarding unit: ALU-after-ALU, MUL occupancy, r0 handling, ALU ops.
    issue(0, OP_ADD, 1, 0, 0, 16'd5,      1'b1, 32'd5,          2, 0);
    issue(0, OP_ADD, 2, 1, 1, 16'd0,      1'b0, 32'd10,         2, 0);
    issue(0, OP_MUL, 3, 1, 2, 16'd0,      1'b0, 32'd50,         5, 0);
    issue(0, OP_ADD, 4, 3, 0, 16'd0,      1'b0, 32'd50,         2, 3);
    issue(0, OP_ADD, 0, 0, 0, 16'd7,      1'b1, 32'd7,          2, 0);
    issue(0, OP_ADD, 5, 0, 0, 16'd0,      1'b0, 32'd0,          2, 0);
    issue(0, OP_SUB, 6, 0, 0, 16'd1,      1'b1, 32'hFFFF_FFFF,  2, 0);
    issue(0, OP_ADD, 7, 0, 0, 16'hFFFF,   1'b1, 32'hFFFF_FFFF,  2, 0);
    issue(0, OP_SLT, 8, 7, 0, 16'd1,      1'b1, 32'd1,          2, 0);
    issue(0, OP_ADD, 9, 0, 0, 16'd1,      1'b1, 32'd1,          2, 0);
    issue(0, OP_SLL, 10, 9, 0, 16'd33,    1'b1, 32'd2,          2, 0);
    issue(0, OP_SRL, 11, 7, 0, 16'd4,     1'b1, 32'h0FFF_FFFF,  2, 0);
    issue(0, OP_AND, 12, 7, 0, 16'h00F0,  1'b1, 32'h0000_00F0,  2, 0);
    issue(0, OP_OR,  13, 2, 0, 16'd5,     1'b1, 32'd15,         2, 0);
    issue(0, OP_SLT, 14, 9, 7, 16'd0,     1'b0, 32'd0,          2, 0);
    idle(8);
    dbg(0, 0, 32'd0);
    dbg(0, 1, 32'd5);
    dbg(0, 2, 32'd10);
    dbg(0, 3, 32'd50);
    dbg(0, 4, 32'd50);
    dbg(0, 6, 32'hFFFF_FFFF);
    dbg(0, 10, 32'd2);
    dbg(0, 11, 32'h0FFF_FFFF);
    dbg(0, 14, 32'd0);
    idle(1);

    // Interlock unit: dependent ADD stalls two cycles, XM bubbles delay its writeback.
    issue(1, OP_ADD, 1, 0, 0, 16'd5, 1'b1, 32'd5,  2, 0);
    issue(1, OP_ADD, 2, 1, 1, 16'd0, 1'b0, 32'd10, 4, 0);
    issue(1, OP_ADD, 3, 0, 0, 16'd3, 1'b1, 32'd3,  2, 2);
    idle(8);
    dbg(1, 2, 32'd10);
    dbg(1, 3, 32'd3);
    idle(1);

    // Reset in the middle of a MUL whose counter has reached 2.
    issue(0, OP_MUL, 15, 1, 2, 16'd0, 1'b0, 32'd50, 5, 0);
    idle(1);
    chk("mid_mul_in_ready", 64'(in_ready_a[0]), 64'(0));
    rst = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    chk("rst_async_wb_valid", 64'(wb_valid_a[0]), 64'(0));
    chk("rst_async_in_ready", 64'(in_ready_a[0]), 64'(1));
    idle(2);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      chk($sformatf("post_rst_wb_valid_c%0d", i), 64'(wb_valid_a[0]), 64'(0));
    end
    for (int a = 0; a < NR; a++) begin
      dbg(0, a, 32'd0);
    end
    dbg(1, 2, 32'd0);
    idle(1);

    chk("u0_sb_empty", 64'(q0.size()), 64'(0));
    chk("u1_sb_empty", 64'(q1.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
